// File: rtl/dla_particle_check_if.sv
// Request/result and VRAM Avalon read signals of the DLA particle checker.
// The checker sits on the slave modport; the requester and the VRAM side
// together form the master modport.

`ifndef H_DISPLAY
`define H_DISPLAY 640
`endif
`ifndef V_DISPLAY
`define V_DISPLAY 480
`endif
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 9
`endif

interface dla_particle_check_if #(
  parameter int AVN_AW = 19,
  parameter int AVN_DW = 16
);
  logic [`H_SIZE-1:0] check_x;
  logic [`V_SIZE-1:0] check_y;
  logic               check_start;
  logic               check_done;
  logic               hit_boundary;
  logic               hit_neighbor;
  logic [AVN_AW-1:0]  vram_avn_address;
  logic               vram_avn_read;
  logic [AVN_DW-1:0]  vram_avn_readdata;
  logic               vram_avn_waitrequest;
  logic               vram_avn_readdatavalid;

  modport slave (
    input  check_x, check_y, check_start,
    input  vram_avn_readdata, vram_avn_waitrequest, vram_avn_readdatavalid,
    output check_done, hit_boundary, hit_neighbor,
    output vram_avn_address, vram_avn_read
  );

  modport master (
    output check_x, check_y, check_start,
    output vram_avn_readdata, vram_avn_waitrequest, vram_avn_readdatavalid,
    input  check_done, hit_boundary, hit_neighbor,
    input  vram_avn_address, vram_avn_read
  );
endinterface

// File: rtl/dla_particle_check.sv
// DLA particle checker: decides whether a particle touches the screen edge
// or any occupied pixel among its 8 neighbours, reading VRAM one word at a
// time and stopping at the first occupied neighbour.

`ifndef H_DISPLAY
`define H_DISPLAY 640
`endif
`ifndef V_DISPLAY
`define V_DISPLAY 480
`endif
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 9
`endif

module dla_particle_check #(
  parameter int AVN_AW    = 19,
  parameter int AVN_DW    = 16,
  parameter int H_DISPLAY = `H_DISPLAY,
  parameter int V_DISPLAY = `V_DISPLAY
) (
  input logic clk,
  input logic rst,
  dla_particle_check_if.slave bus
);

  localparam int XW = `H_SIZE;
  localparam int YW = `V_SIZE;
  localparam logic [XW-1:0] X_MAX = XW'(H_DISPLAY - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_DISPLAY - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    BOUND = 5'b00010,
    READ  = 5'b00100,
    WAIT  = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [2:0]        k;
  logic              done;
  logic              hb;
  logic              hn;
  logic              rd;
  logic [AVN_AW-1:0] addr;

  // Word address of neighbour kv. Offsets are encoded as 0/1/2 and the
  // minus-one is applied after widening, so interior pixels never wrap.
  function automatic logic [AVN_AW-1:0] nbr_addr(input logic [XW-1:0] xv,
                                                 input logic [YW-1:0] yv,
                                                 input logic [2:0]    kv);
    logic [1:0]        dx;
    logic [1:0]        dy;
    logic [AVN_AW-1:0] nx;
    logic [AVN_AW-1:0] ny;
    case (kv)
      3'd0:    begin dx = 2'd0; dy = 2'd0; end
      3'd1:    begin dx = 2'd1; dy = 2'd0; end
      3'd2:    begin dx = 2'd2; dy = 2'd0; end
      3'd3:    begin dx = 2'd0; dy = 2'd1; end
      3'd4:    begin dx = 2'd2; dy = 2'd1; end
      3'd5:    begin dx = 2'd0; dy = 2'd2; end
      3'd6:    begin dx = 2'd1; dy = 2'd2; end
      default: begin dx = 2'd2; dy = 2'd2; end
    endcase
    nx = AVN_AW'(xv) + AVN_AW'(dx) - AVN_AW'(1);
    ny = AVN_AW'(yv) + AVN_AW'(dy) - AVN_AW'(1);
    return nx + ny * AVN_AW'(H_DISPLAY);
  endfunction

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      done  <= 1'b0;
      hb    <= 1'b0;
      hn    <= 1'b0;
      rd    <= 1'b0;
      addr  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.check_start) begin
            x     <= bus.check_x;
            y     <= bus.check_y;
            hb    <= 1'b0;
            hn    <= 1'b0;
            state <= BOUND;
          end
        end
        BOUND: begin
          if (x == '0 || x == X_MAX || y == '0 || y == Y_MAX) begin
            hb    <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k     <= 3'd0;
            addr  <= nbr_addr(x, y, 3'd0);
            rd    <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          if (!bus.vram_avn_waitrequest) begin
            rd    <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.vram_avn_readdatavalid) begin
            if (bus.vram_avn_readdata != '0) begin
              hn    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else if (k == 3'd7) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              k     <= k + 3'd1;
              addr  <= nbr_addr(x, y, k + 3'd1);
              rd    <= 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          rd    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Drive the interface straight from the registers.
  always_comb begin
    bus.check_done       = done;
    bus.hit_boundary     = hb;
    bus.hit_neighbor     = hn;
    bus.vram_avn_read    = rd;
    bus.vram_avn_address = addr;
  end

endmodule

// File: tb/tb_dla_particle_check.sv
// Testbench for dla_particle_check: a small VRAM slave model answers reads,
// expected results and read addresses are queued when a check is issued and
// compared when the DUT presents them.

module tb_dla_particle_check;

  localparam int HD = 640;
  localparam int VD = 480;

  typedef struct {
    int hb;
    int hn;
    int lat;
    int stamp;
  } exp_t;

  logic clk;
  logic rst;

  dla_particle_check_if bus ();

  dla_particle_check dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checkCount = 0;
  int         errorCount = 0;
  int         cycle = 0;
  int         doneCount = 0;
  int         readCount = 0;
  int         acceptCount = 0;
  int         stallBudget = 0;
  logic       lateRdv = 1'b0;
  logic [15:0] mem [int];
  exp_t       expQ[$];
  int         addrQ[$];
  int         dxT[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  int         dyT[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  // Free-running clock and edge counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle = cycle + 1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int pixAddr(input int px, input int py);
    return px + py * HD;
  endfunction

  // Issue one check and queue what the DUT should produce for it.
  task automatic applyStimulus(input int px, input int py, input int extra);
    exp_t e;
    int   found;
    int   a;
    @(negedge clk);
    bus.check_x     = 10'(px);
    bus.check_y     = 9'(py);
    bus.check_start = 1'b1;
    e.stamp = cycle;
    if (px == 0 || px == HD - 1 || py == 0 || py == VD - 1) begin
      e.hb  = 1;
      e.hn  = 0;
      e.lat = 2;
    end else begin
      found = -1;
      for (int i = 0; i < 8; i++) begin
        a = pixAddr(px + dxT[i], py + dyT[i]);
        addrQ.push_back(a);
        if (mem.exists(a) && mem[a] != 16'd0) begin
          found = i;
          break;
        end
      end
      e.hb  = 0;
      e.hn  = (found >= 0) ? 1 : 0;
      e.lat = ((found >= 0) ? 4 + 2 * found : 18) + extra;
    end
    expQ.push_back(e);
    @(negedge clk);
    bus.check_start = 1'b0;
  endtask

  // Wait for every queued result to come back, within a cycle budget.
  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput({tag, "_timeout"}, expQ.size(), 0);
      expQ.delete();
      addrQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_done"}, int'(bus.check_done), 0);
    checkOutput({tag, "_hb"},   int'(bus.hit_boundary), 0);
    checkOutput({tag, "_hn"},   int'(bus.hit_neighbor), 0);
    checkOutput({tag, "_read"}, int'(bus.vram_avn_read), 0);
  endtask

  // VRAM slave: accepts reads, returns data one cycle later, inserts stalls.
  initial begin
    logic       acc;
    logic [15:0] data;
    int         a;
    bus.vram_avn_waitrequest   = 1'b0;
    bus.vram_avn_readdatavalid = 1'b0;
    bus.vram_avn_readdata      = 16'd0;
    forever begin
      @(posedge clk);
      acc  = bus.vram_avn_read && !bus.vram_avn_waitrequest && !rst;
      data = 16'd0;
      if (acc) begin
        acceptCount++;
        a = int'(bus.vram_avn_address);
        if (addrQ.size() == 0) begin
          checkOutput("addr_unexpected", a, -1);
        end else begin
          checkOutput("read_addr", a, addrQ.pop_front());
        end
        if (mem.exists(a)) data = mem[a];
      end
      #1;
      bus.vram_avn_readdatavalid = acc || lateRdv;
      bus.vram_avn_readdata      = acc ? data : (lateRdv ? 16'hffff : 16'd0);
      if (bus.vram_avn_read && stallBudget > 0) begin
        bus.vram_avn_waitrequest = 1'b1;
        stallBudget--;
      end else begin
        bus.vram_avn_waitrequest = 1'b0;
      end
    end
  end

  // Result monitor plus read-hold checking while the slave stalls.
  initial begin
    exp_t        e;
    logic        prevStall;
    logic [18:0] prevAddr;
    prevStall = 1'b0;
    prevAddr  = '0;
    forever begin
      @(negedge clk);
      if (bus.vram_avn_read) readCount++;
      if (prevStall && !rst) begin
        checkOutput("stall_read", int'(bus.vram_avn_read), 1);
        checkOutput("stall_addr", int'(bus.vram_avn_address), int'(prevAddr));
      end
      prevStall = bus.vram_avn_read && bus.vram_avn_waitrequest;
      prevAddr  = bus.vram_avn_address;
      if (bus.check_done) begin
        doneCount++;
        checkOutput("exclusive", int'(bus.hit_boundary && bus.hit_neighbor), 0);
        if (expQ.size() == 0) begin
          checkOutput("done_unexpected", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("hit_boundary", int'(bus.hit_boundary), e.hb);
          checkOutput("hit_neighbor", int'(bus.hit_neighbor), e.hn);
          checkOutput("latency", cycle - e.stamp, e.lat);
        end
      end
    end
  end

  // Global guard so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    int rc;
    int dc;
    int n;
    rst = 1'b1;
    bus.check_x     = '0;
    bus.check_y     = '0;
    bus.check_start = 1'b0;
    repeat (3) @(negedge clk);
    checkQuiet("reset");
    checkOutput("reset_addr", int'(bus.vram_avn_address), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] boundary cases");
    rc = readCount;
    applyStimulus(0, 100, 0);
    waitDone("b_left", 40);
    applyStimulus(639, 5, 0);
    waitDone("b_right", 40);
    applyStimulus(5, 0, 0);
    waitDone("b_top", 40);
    applyStimulus(5, 479, 0);
    waitDone("b_bottom", 40);
    checkOutput("boundary_no_read", readCount - rc, 0);

    $display("[TB] empty neighbourhood");
    applyStimulus(100, 100, 0);
    waitDone("empty", 60);
    applyStimulus(1, 1, 0);
    waitDone("corner_empty", 60);

    $display("[TB] occupied neighbours");
    mem[pixAddr(101, 100)] = 16'h0001;
    applyStimulus(100, 100, 0);
    waitDone("k4", 60);
    mem[pixAddr(0, 0)] = 16'h8000;
    applyStimulus(1, 1, 0);
    waitDone("k0", 60);
    mem[pixAddr(639, 479)] = 16'h0100;
    applyStimulus(638, 478, 0);
    waitDone("k7", 60);

    $display("[TB] waitrequest on first read");
    stallBudget = 3;
    applyStimulus(200, 200, 3);
    waitDone("stall", 80);

    $display("[TB] reset during WAIT");
    mem[pixAddr(299, 299)] = 16'h0001;
    n = acceptCount;
    applyStimulus(300, 300, 0);
    rc = 0;
    while (acceptCount == n && rc < 20) begin
      @(negedge clk);
      rc++;
    end
    checkOutput("rst_read_seen", int'(acceptCount != n), 1);
    if (acceptCount == n) @(negedge clk);
    rst = 1'b1;
    #1;
    expQ.delete();
    addrQ.delete();
    checkQuiet("rst_async");
    checkOutput("rst_addr", int'(bus.vram_avn_address), 0);
    @(negedge clk);
    rst = 1'b0;
    lateRdv = 1'b1;
    repeat (2) @(negedge clk);
    lateRdv = 1'b0;
    repeat (3) @(negedge clk);
    checkQuiet("rst_late");
    applyStimulus(639, 5, 0);
    waitDone("rst_restart", 40);

    $display("[TB] start re-pulsed while busy");
    dc = doneCount;
    applyStimulus(100, 100, 0);
    repeat (2) @(negedge clk);
    bus.check_x     = 10'd0;
    bus.check_y     = 9'd0;
    bus.check_start = 1'b1;
    @(negedge clk);
    bus.check_start = 1'b0;
    waitDone("repulse", 60);
    repeat (25) @(negedge clk);
    checkOutput("repulse_done_count", doneCount - dc, 1);
    checkOutput("repulse_hn_hold", int'(bus.hit_neighbor), 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
